// File: rtl/volume_aplicador_pkg.sv
// Shared definitions for the volume applicator: gain range, gain type and the Q7 gain table.
package volume_pkg;

  localparam int unsigned VOLUME_MAX = 10;

  typedef logic [3:0] ganho_t;

  // Gain 0..10 in Q7 (128 = unity); out-of-range codes saturate to unity.
  function automatic logic [7:0] ganho_q7(input ganho_t g);
    logic [7:0] q;
    case (g)
      4'd0:    q = 8'd0;
      4'd1:    q = 8'd13;
      4'd2:    q = 8'd26;
      4'd3:    q = 8'd38;
      4'd4:    q = 8'd51;
      4'd5:    q = 8'd64;
      4'd6:    q = 8'd77;
      4'd7:    q = 8'd90;
      4'd8:    q = 8'd102;
      4'd9:    q = 8'd115;
      default: q = 8'd128;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/volume_aplicador_rampa_ganho.sv
// Target capture/clamp of the BCD volume and gain ramp toward it.
// Ramp enabled by macro VOLUME_RAMPA_EN; otherwise the gain follows the target one edge later.
module rampa_ganho
  import volume_pkg::*;
#(
  parameter int unsigned PASSO_RAMPA = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] volume1_i,
  input  logic [3:0] volume0_i,
  input  logic       mudou_i,
  output logic [3:0] ganho_o,
  output logic       em_rampa_o
);

  logic [7:0] soma;
  ganho_t     alvo_q, alvo_d;
  ganho_t     ganho_q, ganho_d;

  always_comb begin
    soma   = 8'(volume1_i) * 8'd10 + 8'(volume0_i);
    alvo_d = alvo_q;
    if (mudou_i) begin
      if (volume0_i > 4'd9 || soma > 8'(VOLUME_MAX)) alvo_d = ganho_t'(VOLUME_MAX);
      else                                           alvo_d = soma[3:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) alvo_q <= '0;
    else         alvo_q <= alvo_d;
  end

`ifdef VOLUME_RAMPA_EN
  localparam int unsigned      CNT_W      = (PASSO_RAMPA > 1) ? $clog2(PASSO_RAMPA) : 1;
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(PASSO_RAMPA - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             em_rampa_q, em_rampa_d;

  // Counter is deliberately not cleared on retarget; the step direction is re-evaluated at each wrap.
  always_comb begin
    ganho_d    = ganho_q;
    cnt_d      = cnt_q;
    em_rampa_d = (ganho_q != alvo_q);
    if (ganho_q == alvo_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_ULTIMO) begin
      cnt_d   = '0;
      ganho_d = (alvo_q > ganho_q) ? ganho_q + 1'b1 : ganho_q - 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ganho_q    <= '0;
      cnt_q      <= '0;
      em_rampa_q <= 1'b0;
    end else begin
      ganho_q    <= ganho_d;
      cnt_q      <= cnt_d;
      em_rampa_q <= em_rampa_d;
    end
  end

  assign em_rampa_o = em_rampa_q;
`else
  logic unused_passo;
  assign unused_passo = (PASSO_RAMPA > 0);

  always_comb ganho_d = alvo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ganho_q <= '0;
    else         ganho_q <= ganho_d;
  end

  assign em_rampa_o = 1'b0;
`endif

  assign ganho_o = ganho_q;

endmodule

// File: rtl/volume_aplicador.sv
// Scales the signed sample stream by the active Q7 gain through a one-stage valid/ready register.
// Ramped gain changes when VOLUME_RAMPA_EN is defined; immediate changes otherwise.
module volume_aplicador
  import volume_pkg::*;
#(
  parameter int unsigned LARGURA     = 16,
  parameter int unsigned PASSO_RAMPA = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         volume1,
  input  logic [3:0]         volume0,
  input  logic               mudou_volume,
  input  logic [LARGURA-1:0] amostra_in,
  input  logic               amostra_in_valid,
  output logic               amostra_in_ready,
  output logic [LARGURA-1:0] amostra_out,
  output logic               amostra_out_valid,
  input  logic               amostra_out_ready,
  output logic [3:0]         ganho_atual,
  output logic               em_rampa
);

  rampa_ganho #(
    .PASSO_RAMPA(PASSO_RAMPA)
  ) u_rampa (
    .clk_i     (clk),
    .rst_ni    (reset),
    .volume1_i (volume1),
    .volume0_i (volume0),
    .mudou_i   (mudou_volume),
    .ganho_o   (ganho_atual),
    .em_rampa_o(em_rampa)
  );

  logic [7:0]                q7;
  logic signed [LARGURA+7:0] produto;
  logic [LARGURA-1:0]        escalado;
  logic                      unused_produto;

  // Taking bits [LARGURA+6:7] of the two's-complement product is the floor of >>> 7.
  always_comb begin
    q7       = ganho_q7(ganho_atual);
    produto  = $signed({{8{amostra_in[LARGURA-1]}}, amostra_in}) * $signed({{LARGURA{1'b0}}, q7});
    escalado = produto[LARGURA+6:7];
  end

  assign unused_produto = ^{produto[LARGURA+7], produto[6:0]};

  logic [LARGURA-1:0] saida_q, saida_d;
  logic               valid_q, valid_d;

  assign amostra_in_ready = !valid_q || amostra_out_ready;

  always_comb begin
    saida_d = saida_q;
    valid_d = valid_q;
    if (amostra_in_valid && amostra_in_ready) begin
      saida_d = escalado;
      valid_d = 1'b1;
    end else if (amostra_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saida_q <= '0;
      valid_q <= 1'b0;
    end else begin
      saida_q <= saida_d;
      valid_q <= valid_d;
    end
  end

  assign amostra_out       = saida_q;
  assign amostra_out_valid = valid_q;

endmodule
